// File: rtl/interp_row_sequencer.sv
// Row sequencer feeding an interpolation filter: walks integer rows, integer
// columns (transpose) and one selected half-sample array, one row per beat,
// over a valid/ready handshake with a registered output row.
module interp_row_sequencer #(
    parameter int unsigned NUM_PIXEL = 8,
    parameter int unsigned PIX_W     = 8,
    localparam int unsigned ROW_LEN  = NUM_PIXEL + 7,
    localparam int unsigned ROW_W    = ROW_LEN * PIX_W,
    localparam int unsigned IDX_W    = $clog2(ROW_LEN)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode,
    input  logic [1:0]                    half_sel,
    input  logic                          flush,
    input  logic [ROW_LEN*ROW_W-1:0]      integer_array,
    input  logic [NUM_PIXEL*ROW_W-1:0]    half_array_a,
    input  logic [NUM_PIXEL*ROW_W-1:0]    half_array_b,
    input  logic [NUM_PIXEL*ROW_W-1:0]    half_array_c,
    output logic [ROW_W-1:0]              out_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    out_kind,
    output logic [IDX_W-1:0]              out_index,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned HIDX_W    = (NUM_PIXEL > 1) ? $clog2(NUM_PIXEL) : 1;
    localparam int unsigned COL_FIRST = 3;

    localparam logic [1:0] KIND_ROW  = 2'd0;
    localparam logic [1:0] KIND_COL  = 2'd1;
    localparam logic [1:0] KIND_HALF = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INT_ROW,
        S_INT_COL,
        S_HALF_ROW
    } state_t;

    state_t             state;
    logic               mode_q;
    logic [1:0]         half_q;

    logic               xfer;
    logic               load;
    logic               seq_end;
    state_t             nxt_state;
    logic [1:0]         nxt_kind;
    logic [IDX_W-1:0]   nxt_idx;
    logic [IDX_W-1:0]   col_last;
    logic [HIDX_W-1:0]  hidx;

    logic [ROW_W-1:0]   int_rows [ROW_LEN];
    logic [PIX_W-1:0]   int_pix  [ROW_LEN][ROW_LEN];
    logic [ROW_W-1:0]   half_a_rows [NUM_PIXEL];
    logic [ROW_W-1:0]   half_b_rows [NUM_PIXEL];
    logic [ROW_W-1:0]   half_c_rows [NUM_PIXEL];
    logic [ROW_W-1:0]   col_row;
    logic [ROW_W-1:0]   sel_row;

    // Unpack the flat integer array into rows and a pixel matrix
    for (genvar r = 0; r < ROW_LEN; r++) begin : g_int_row
        assign int_rows[r] = integer_array[r*ROW_W +: ROW_W];
        for (genvar c = 0; c < ROW_LEN; c++) begin : g_int_pix
            assign int_pix[r][c] = integer_array[r*ROW_W + c*PIX_W +: PIX_W];
        end
    end

    // Unpack the three half-sample arrays into rows
    for (genvar h = 0; h < NUM_PIXEL; h++) begin : g_half_row
        assign half_a_rows[h] = half_array_a[h*ROW_W +: ROW_W];
        assign half_b_rows[h] = half_array_b[h*ROW_W +: ROW_W];
        assign half_c_rows[h] = half_array_c[h*ROW_W +: ROW_W];
    end

    // Transpose column at the next beat index: pixel k comes from integer row k
    for (genvar k = 0; k < ROW_LEN; k++) begin : g_col
        assign col_row[k*PIX_W +: PIX_W] = int_pix[k][nxt_idx];
    end

    assign hidx     = nxt_idx[HIDX_W-1:0];
    assign col_last = mode_q ? IDX_W'(COL_FIRST + NUM_PIXEL - 1) : IDX_W'(ROW_LEN - 1);
    assign xfer     = out_valid && out_ready;

    // Next beat selection: which phase and index the following beat presents
    always_comb begin
        load      = 1'b0;
        seq_end   = 1'b0;
        nxt_state = state;
        nxt_kind  = out_kind;
        nxt_idx   = out_index;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (mode) begin
                        nxt_state = S_INT_COL;
                        nxt_kind  = KIND_COL;
                        nxt_idx   = IDX_W'(COL_FIRST);
                    end else begin
                        nxt_state = S_INT_ROW;
                        nxt_kind  = KIND_ROW;
                        nxt_idx   = '0;
                    end
                end
            end
            S_INT_ROW: begin
                if (xfer) begin
                    load = 1'b1;
                    if (out_index == IDX_W'(ROW_LEN - 1)) begin
                        nxt_state = S_INT_COL;
                        nxt_kind  = KIND_COL;
                        nxt_idx   = '0;
                    end else begin
                        nxt_idx = out_index + IDX_W'(1);
                    end
                end
            end
            S_INT_COL: begin
                if (xfer) begin
                    load = 1'b1;
                    if (out_index == col_last) begin
                        nxt_state = S_HALF_ROW;
                        nxt_kind  = KIND_HALF;
                        nxt_idx   = '0;
                    end else begin
                        nxt_idx = out_index + IDX_W'(1);
                    end
                end
            end
            S_HALF_ROW: begin
                if (xfer) begin
                    if (out_index == IDX_W'(NUM_PIXEL - 1)) begin
                        seq_end   = 1'b1;
                        nxt_state = S_IDLE;
                    end else begin
                        load    = 1'b1;
                        nxt_idx = out_index + IDX_W'(1);
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Row contents for the next beat; half_sel 3 aliases array A
    always_comb begin
        sel_row = '0;
        case (nxt_kind)
            KIND_ROW: sel_row = int_rows[nxt_idx];
            KIND_COL: sel_row = col_row;
            default: begin
                case (half_q)
                    2'd1:    sel_row = half_b_rows[hidx];
                    2'd2:    sel_row = half_c_rows[hidx];
                    default: sel_row = half_a_rows[hidx];
                endcase
            end
        endcase
    end

    // Sequencer state and registered outputs; flush overrides start and transfer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            mode_q    <= 1'b0;
            half_q    <= 2'd0;
            out_row   <= '0;
            out_valid <= 1'b0;
            out_kind  <= KIND_ROW;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= nxt_state;
            done  <= seq_end;
            if (state == S_IDLE && start) begin
                mode_q    <= mode;
                half_q    <= half_sel;
                busy      <= 1'b1;
                out_valid <= 1'b1;
            end
            if (seq_end) begin
                busy      <= 1'b0;
                out_valid <= 1'b0;
            end
            if (load) begin
                out_kind  <= nxt_kind;
                out_index <= nxt_idx;
                out_row   <= sel_row;
            end
        end
    end

endmodule

// File: tb/tb_interp_row_sequencer.sv
// Scoreboard bench for interp_row_sequencer: a pixel-level model queues the
// expected beats at each start, a negedge monitor pops and compares them.
module tb_interp_row_sequencer;

    localparam int unsigned NUM_PIXEL = 8;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned ROW_LEN   = NUM_PIXEL + 7;
    localparam int unsigned ROW_W     = ROW_LEN * PIX_W;
    localparam int unsigned IDX_W     = $clog2(ROW_LEN);
    localparam int unsigned CW        = ROW_W + 8;

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic                         start = 1'b0;
    logic                         mode = 1'b0;
    logic [1:0]                   half_sel = 2'd0;
    logic                         flush = 1'b0;
    logic                         out_ready = 1'b0;
    logic [ROW_LEN*ROW_W-1:0]     integer_array;
    logic [NUM_PIXEL*ROW_W-1:0]   half_array_a;
    logic [NUM_PIXEL*ROW_W-1:0]   half_array_b;
    logic [NUM_PIXEL*ROW_W-1:0]   half_array_c;
    logic [ROW_W-1:0]             out_row;
    logic                         out_valid;
    logic [1:0]                   out_kind;
    logic [IDX_W-1:0]             out_index;
    logic                         busy;
    logic                         done;

    typedef struct {
        logic [1:0]       kind;
        logic [IDX_W-1:0] idx;
        logic [ROW_W-1:0] row;
        bit               last;
    } beat_t;

    int unsigned ipix [ROW_LEN][ROW_LEN];
    int unsigned hpix [3][NUM_PIXEL][ROW_LEN];
    beat_t       exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          xfer_count = 0;
    int unsigned stall_pct = 0;
    bit          pending_done = 1'b0;

    interp_row_sequencer #(.NUM_PIXEL(NUM_PIXEL), .PIX_W(PIX_W)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .half_sel(half_sel), .flush(flush), .integer_array(integer_array),
        .half_array_a(half_array_a), .half_array_b(half_array_b),
        .half_array_c(half_array_c), .out_row(out_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_index(out_index),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    function automatic void check(input string name, input logic [CW-1:0] act,
                                  input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Model rows built from the pixel tables
    function automatic logic [ROW_W-1:0] int_row(input int r);
        logic [ROW_W-1:0] v;
        for (int k = 0; k < ROW_LEN; k++) v[k*PIX_W +: PIX_W] = PIX_W'(ipix[r][k]);
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] int_col(input int c);
        logic [ROW_W-1:0] v;
        for (int k = 0; k < ROW_LEN; k++) v[k*PIX_W +: PIX_W] = PIX_W'(ipix[k][c]);
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] half_row(input int s, input int h);
        logic [ROW_W-1:0] v;
        for (int k = 0; k < ROW_LEN; k++) v[k*PIX_W +: PIX_W] = PIX_W'(hpix[s][h][k]);
        return v;
    endfunction

    function automatic void push_beat(input logic [1:0] kind, input int idx,
                                      input logic [ROW_W-1:0] row, input bit last);
        beat_t b;
        b.kind = kind;
        b.idx  = IDX_W'(idx);
        b.row  = row;
        b.last = last;
        exp_q.push_back(b);
    endfunction

    // Expected beat list for one sequence
    function automatic void push_model(input bit m, input logic [1:0] hs);
        int s;
        int c0;
        int nc;
        s  = (hs == 2'd1) ? 1 : (hs == 2'd2) ? 2 : 0;
        c0 = m ? 3 : 0;
        nc = m ? NUM_PIXEL : ROW_LEN;
        if (!m) for (int r = 0; r < ROW_LEN; r++) push_beat(2'd0, r, int_row(r), 1'b0);
        for (int c = c0; c < c0 + nc; c++) push_beat(2'd1, c, int_col(c), 1'b0);
        for (int h = 0; h < NUM_PIXEL; h++)
            push_beat(2'd2, h, half_row(s, h), h == NUM_PIXEL - 1);
    endfunction

    task automatic fill(input bit ramp);
        for (int r = 0; r < ROW_LEN; r++)
            for (int k = 0; k < ROW_LEN; k++)
                ipix[r][k] = ramp ? 16*r + k : $urandom_range(255);
        for (int s = 0; s < 3; s++)
            for (int h = 0; h < NUM_PIXEL; h++)
                for (int k = 0; k < ROW_LEN; k++) hpix[s][h][k] = $urandom_range(255);
        for (int r = 0; r < ROW_LEN; r++)
            for (int k = 0; k < ROW_LEN; k++)
                integer_array[(r*ROW_LEN + k)*PIX_W +: PIX_W] = PIX_W'(ipix[r][k]);
        for (int h = 0; h < NUM_PIXEL; h++)
            for (int k = 0; k < ROW_LEN; k++) begin
                half_array_a[(h*ROW_LEN + k)*PIX_W +: PIX_W] = PIX_W'(hpix[0][h][k]);
                half_array_b[(h*ROW_LEN + k)*PIX_W +: PIX_W] = PIX_W'(hpix[1][h][k]);
                half_array_c[(h*ROW_LEN + k)*PIX_W +: PIX_W] = PIX_W'(hpix[2][h][k]);
            end
    endtask

    // Called at posedge+1; returns at posedge+1 of cycle 1 after the start cycle
    task automatic issue_start(input bit m, input logic [1:0] hs);
        push_model(m, hs);
        mode     = m;
        half_sel = hs;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input int exp_cycle, input string name);
        int cyc;
        cyc = 1;
        while (done !== 1'b1 && cyc < bound) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check({name, "_seen"}, CW'(done), CW'(1));
        if (exp_cycle > 0) check({name, "_cycle"}, CW'(cyc), CW'(exp_cycle));
    endtask

    // Downstream ready, low with probability stall_pct percent
    initial begin : ready_gen
        forever begin
            @(posedge clock);
            #1;
            out_ready = ($urandom_range(99) >= stall_pct);
        end
    end

    // Monitor: done timing, stall stability, and in-order beat scoreboard
    initial begin : monitor
        beat_t            e;
        logic [ROW_W-1:0] hold_row;
        logic [1:0]       hold_kind;
        logic [IDX_W-1:0] hold_idx;
        bit               hold_valid;
        hold_valid = 1'b0;
        hold_row   = '0;
        hold_kind  = '0;
        hold_idx   = '0;
        forever begin
            @(negedge clock);
            check("done_pulse", CW'(done), CW'(pending_done));
            pending_done = 1'b0;
            if (!reset || flush) begin
                exp_q.delete();
                hold_valid = 1'b0;
            end else begin
                if (hold_valid)
                    check("stall_hold", CW'({out_valid, out_kind, out_index, out_row}),
                          CW'({1'b1, hold_kind, hold_idx, hold_row}));
                if (out_valid && out_ready) begin
                    hold_valid = 1'b0;
                    xfer_count++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got kind %0d index %0d, required no beat",
                                 out_kind, out_index);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_row", CW'(out_row), CW'(e.row));
                        check("beat_kind", CW'(out_kind), CW'(e.kind));
                        check("beat_index", CW'(out_index), CW'(e.idx));
                        if (e.last) pending_done = 1'b1;
                    end
                end else if (out_valid) begin
                    hold_row   = out_row;
                    hold_kind  = out_kind;
                    hold_idx   = out_index;
                    hold_valid = 1'b1;
                end else begin
                    hold_valid = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        fill(1'b1);
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_ctrl", CW'({out_valid, busy, done, out_kind, out_index}), CW'(0));
        check("reset_row", CW'(out_row), CW'(0));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // First round, no stalls, ramp integer data
        stall_pct  = 0;
        xfer_count = 0;
        issue_start(1'b0, 2'd0);
        check("s1_first_busy_valid", CW'({busy, out_valid}), CW'(2'b11));
        wait_done(100, 39, "s1_done");
        check("s1_xfers", CW'(xfer_count), CW'(38));

        // Second round, half array B
        fill(1'b1);
        xfer_count = 0;
        issue_start(1'b1, 2'd1);
        check("s2_first_kind_index", CW'({out_kind, out_index}), CW'({2'd1, 4'd3}));
        wait_done(100, 17, "s2_done");
        check("s2_xfers", CW'(xfer_count), CW'(16));

        // Random stalls, same order as the no-stall first round (sel 3 aliases A)
        stall_pct  = 30;
        xfer_count = 0;
        issue_start(1'b0, 2'd3);
        wait_done(600, 0, "s3_done");
        check("s3_xfers", CW'(xfer_count), CW'(38));
        fill(1'b0);
        xfer_count = 0;
        issue_start(1'b1, 2'd2);
        wait_done(400, 0, "s3b_done");
        check("s3b_xfers", CW'(xfer_count), CW'(16));

        // Flush at beat 20 together with start and a transfer
        stall_pct = 0;
        fill(1'b0);
        issue_start(1'b0, 2'd0);
        repeat (20) begin
            @(posedge clock);
            #1;
        end
        flush = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check("s4_flush_idle", CW'({out_valid, busy}), CW'(0));
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        check("s4_still_idle", CW'({out_valid, busy}), CW'(0));
        issue_start(1'b0, 2'd1);
        wait_done(100, 39, "s4_restart");

        // Asynchronous reset mid integer-column phase
        fill(1'b0);
        issue_start(1'b0, 2'd2);
        repeat (20) begin
            @(posedge clock);
            #1;
        end
        #2 reset = 1'b0;
        #1;
        check("s5_async_ctrl", CW'({out_valid, busy, done, out_kind, out_index}), CW'(0));
        check("s5_async_row", CW'(out_row), CW'(0));
        @(posedge clock);
        #1;
        start = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b0;
        #2 reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("s5_idle_after_reset", CW'({out_valid, busy}), CW'(0));

        // Back-to-back with ignored start pulses while busy
        fill(1'b0);
        issue_start(1'b1, 2'd2);
        for (int i = 1; i < 16; i++) begin
            start    = 1'($urandom_range(1));
            mode     = 1'($urandom_range(1));
            half_sel = 2'($urandom_range(3));
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        @(posedge clock);
        #1;
        check("s6_done_cycle17", CW'(done), CW'(1));
        issue_start(1'b0, 2'd0);
        check("s6_next_first", CW'({busy, out_valid, out_kind, out_index}),
              CW'({2'b11, 2'd0, 4'd0}));
        wait_done(100, 39, "s6_second");

        repeat (3) @(posedge clock);
        #1;
        check("queue_empty", CW'(exp_q.size()), CW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interp_row_sequencer.md
INTERP_ROW_SEQUENCER -- requirements
Module: interp_row_sequencer

Interface
REQ-001 SHALL have parameter NUM_PIXEL, default 8: output block edge in pixels.
REQ-002 SHALL have parameter PIX_W, default 8: bits per sample.
REQ-003 SHALL derive ROW_LEN = NUM_PIXEL+7, ROW_W = ROW_LEN*PIX_W and IDX_W = ceil(log2(ROW_LEN)).
REQ-004 SHALL have ports:
- clock, input, 1: sole clock; all logic on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request a new sequence.
- mode, input, 1: 0 = first round, 1 = second round.
- half_sel, input, 2: half array select; 0 = A, 1 = B, 2 = C, 3 = A.
- flush, input, 1: synchronous abort.
- integer_array, input, ROW_LEN*ROW_W: integer rows.
- half_array_a, half_array_b, half_array_c, input, NUM_PIXEL*ROW_W each: half-sample rows.
- out_row, output, ROW_W: filter-input row.
- out_valid, output, 1: out_row valid.
- out_ready, input, 1: downstream accepts.
- out_kind, output, 2: 0 = integer row, 1 = integer column, 2 = half row.
- out_index, output, IDX_W: row or column index of the current beat.
- busy, output, 1: sequence in progress.
- done, output, 1: one-cycle completion pulse.

Function
REQ-005 SHALL address integer row r at integer_array[r*ROW_W +: ROW_W] and pixel k of any row at [k*PIX_W +: PIX_W]; half rows SHALL use the same layout.
REQ-006 SHALL implement states IDLE, INT_ROW, INT_COL, HALF_ROW.
REQ-007 SHALL, in IDLE with start=1 and flush=0, latch mode and half_sel, set busy=1, and present the first beat with out_valid=1 on the next cycle.
REQ-008 SHALL ignore start while busy=1.
REQ-009 SHALL produce the first-round sequence as follows:
- INT_ROW: ROW_LEN beats, where beat r is integer row r.
- INT_COL: ROW_LEN beats, where beat c is the transpose column, pixel k = integer row k, pixel c.
- HALF_ROW: NUM_PIXEL beats, where beat h is row h of the selected half array.
REQ-010 SHALL produce the second-round sequence as follows:
- Skip INT_ROW.
- INT_COL: NUM_PIXEL beats at columns 3 .. 3+NUM_PIXEL-1, with out_index equal to the column number.
- HALF_ROW: NUM_PIXEL beats as in REQ-009.
REQ-011 SHALL advance a beat only on out_valid and out_ready both high; otherwise out_row, out_kind and out_index SHALL hold stable.
REQ-012 SHALL sustain one beat per cycle while out_ready stays high, with no bubbles between states.
REQ-013 SHALL, on transfer of the final HALF_ROW beat, drive out_valid=0 and busy=0, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-014 SHALL accept a start asserted during the done cycle, starting the next sequence one cycle later.
REQ-015 SHALL, on flush=1 in any state, enter IDLE next cycle with out_valid=0, busy=0 and no done pulse; flush SHALL take priority over start and over a simultaneous transfer.
REQ-016 SHALL read integer_array and the half arrays combinationally each beat; upstream holds them stable while busy=1.
REQ-017 SHALL register out_row, so that beat contents appear one cycle after the selecting index.
REQ-018 SHALL wrap no counter; counters reset to 0 at each start.

Reset
REQ-019 SHALL, while reset=0, force IDLE and drive out_row=0, out_valid=0, out_kind=0, out_index=0, busy=0 and done=0.
REQ-020 SHALL, when reset is asserted mid-sequence, abandon the sequence with no done pulse; after release, the block waits for a new start.

Verification
REQ-021 Directed scenarios, with defaults NUM_PIXEL=8 (ROW_LEN=15, ROW_W=120):
- First round, out_ready held 1, integer pixel(r,c)=16r+c: 38 consecutive beats; beat 15 pixel k = 16k+0; beat 29 pixel k = 16k+14; then 8 half_array_a rows; done on cycle 39 after start.
- Second round, half_sel=1: 16 beats; first beat kind=1, index=3, pixel k = 16k+3; last 8 beats are half_array_b rows 0..7.
- Random out_ready stalls, 30% low: every beat holds stable during stall; total transfers 38; order identical to the no-stall run.
- flush at beat 20, concurrent with start and a transfer: next cycle out_valid=0, busy=0, done never pulses; a later start restarts at integer row 0.
- Async reset=0 mid-INT_COL between clock edges: outputs go to 0 immediately; start is ignored while reset=0.
- Back-to-back: start held during done cycle -> second sequence begins next cycle; start pulses during busy are ignored.
